// File: rtl/clock_step_pkg.sv
// rtl/clock_step_pkg.sv - shared state type, defaults and next-state rule for the clock step controller
//
// Purpose:
//   Holds the controller state enumeration, the default parameter values
//   used by clock_step_control and step_debounce, and the next-state rule
//   so the top-level FSM stays a thin two-process wrapper.
// Contents:
//   DEBOUNCE_CYCLES_DEF  default debounce window (10 ms at 10 MHz)
//   CNT_W_DEF            default STEP_CNT width
//   state_t              STOP / RUN / HLT
//   next_state()         transition rule; HALT outranks MODE_RUN

package clock_step_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 100000;
  localparam int CNT_W_DEF           = 16;

  typedef enum logic [1:0] {
    STOP = 2'd0,
    RUN  = 2'd1,
    HLT  = 2'd2
  } state_t;

  // HLT is only left once the halt request is gone and the run switch is
  // off, so a processor cannot slip straight from halt back into free-run.
  function automatic state_t next_state(input state_t cur,
                                        input logic   mode_run,
                                        input logic   halt);
    state_t nxt;
    nxt = cur;
    case (cur)
      STOP: begin
        if (halt)          nxt = HLT;
        else if (mode_run) nxt = RUN;
      end
      RUN: begin
        if (halt)           nxt = HLT;
        else if (!mode_run) nxt = STOP;
      end
      HLT: begin
        if (!halt && !mode_run) nxt = STOP;
      end
      default: nxt = STOP;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/step_debounce.sv
// rtl/step_debounce.sv - synchronizer and debouncer for the single-step push-button
//
// Purpose:
//   Brings the raw button into the clock domain through two flops, then
//   only accepts a new level after it has disagreed with the accepted
//   (stable) level for DEBOUNCE_CYCLES consecutive cycles. A one-cycle
//   strobe marks every accepted 0->1 change, so holding the button gives
//   exactly one strobe.
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   btn_raw      raw, bouncy button (1 = pressed)
//   press_pulse  one-cycle strobe on an accepted press

module step_debounce
  import clock_step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press_pulse
);

  localparam int             CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [CW-1:0] cnt;
  logic          differ;
  logic          at_last;

  assign differ  = (sync2 != stable);
  assign at_last = (cnt == LAST);

  // cnt holds how many consecutive samples have already disagreed; the
  // sample that would make it DEBOUNCE_CYCLES flips the stable level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      stable      <= 1'b0;
      cnt         <= '0;
      press_pulse <= 1'b0;
    end else begin
      sync1       <= btn_raw;
      sync2       <= sync1;
      press_pulse <= 1'b0;
      if (!differ) begin
        cnt <= '0;
      end else if (at_last) begin
        cnt         <= '0;
        stable      <= sync2;
        press_pulse <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/clock_step_control.sv
// rtl/clock_step_control.sv - run / single-step / halt controller issuing processor advance enables
//
// Purpose:
//   Turns the slow divided tick (free-run) or a debounced step button
//   (single-step) into one-cycle CPU_EN strobes, honouring a processor
//   halt request. Everything runs on IN_CLK; TICK_IN is only sampled.
// Ports:
//   IN_CLK    10 MHz system clock
//   RST_N     asynchronous active-low reset
//   TICK_IN   10 Hz divided clock, asynchronous, edge-detected
//   MODE_RUN  raw switch, 1 = free-run, 0 = single-step
//   STEP_BTN  raw bouncy button, 1 = pressed
//   HALT      halt request, synchronous level
//   CPU_EN    one-cycle advance enable
//   RUNNING   state is RUN
//   HALTED    state is HLT
//   STEP_CNT  number of CPU_EN strobes issued (wraps)

module clock_step_control
  import clock_step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic             IN_CLK,
  input  logic             RST_N,
  input  logic             TICK_IN,
  input  logic             MODE_RUN,
  input  logic             STEP_BTN,
  input  logic             HALT,
  output logic             CPU_EN,
  output logic             RUNNING,
  output logic             HALTED,
  output logic [CNT_W-1:0] STEP_CNT
);

  // Tick path: two synchronizer flops, two edge-detect taps, one
  // registered strobe. tick_vld fills with ones after reset; until the
  // older edge-detect tap holds a real post-reset sample, no edge is
  // accepted, so a tick already high when reset lifts is discarded.
  logic       tick_s1;
  logic       tick_s2;
  logic       tick_d3;
  logic       tick_d4;
  logic [3:0] tick_vld;
  logic       tick_pulse;

  logic       mode_s1;
  logic       mode_s2;

  logic       press_pulse;

  state_t     state;
  state_t     state_nxt;
  logic       cpu_en_nxt;

  always_ff @(posedge IN_CLK or negedge RST_N) begin
    if (!RST_N) begin
      tick_s1    <= 1'b0;
      tick_s2    <= 1'b0;
      tick_d3    <= 1'b0;
      tick_d4    <= 1'b0;
      tick_vld   <= '0;
      tick_pulse <= 1'b0;
      mode_s1    <= 1'b0;
      mode_s2    <= 1'b0;
    end else begin
      tick_s1    <= TICK_IN;
      tick_s2    <= tick_s1;
      tick_d3    <= tick_s2;
      tick_d4    <= tick_d3;
      tick_vld   <= {tick_vld[2:0], 1'b1};
      tick_pulse <= tick_vld[3] & tick_d3 & ~tick_d4;
      mode_s1    <= MODE_RUN;
      mode_s2    <= mode_s1;
    end
  end

  step_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk        (IN_CLK),
    .rst_n      (RST_N),
    .btn_raw    (STEP_BTN),
    .press_pulse(press_pulse)
  );

  // A strobe is only honoured when the state is settled: a halt request
  // or a state change in the same cycle swallows it rather than letting
  // the processor advance across a mode boundary.
  always_comb begin
    state_nxt  = next_state(state, mode_s2, HALT);
    cpu_en_nxt = 1'b0;
    if (!HALT && (state_nxt == state)) begin
      if ((state == RUN) && tick_pulse)   cpu_en_nxt = 1'b1;
      if ((state == STOP) && press_pulse) cpu_en_nxt = 1'b1;
    end
  end

  // RUNNING/HALTED are loaded from the next state so that they are flops
  // yet always agree with the state register.
  always_ff @(posedge IN_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= STOP;
      CPU_EN   <= 1'b0;
      RUNNING  <= 1'b0;
      HALTED   <= 1'b0;
      STEP_CNT <= '0;
    end else begin
      state   <= state_nxt;
      CPU_EN  <= cpu_en_nxt;
      RUNNING <= (state_nxt == RUN);
      HALTED  <= (state_nxt == HLT);
      if (cpu_en_nxt) STEP_CNT <= STEP_CNT + 1'b1;
    end
  end

endmodule

// File: tb/tb_clock_step_control.sv
// tb/tb_clock_step_control.sv - self-checking bench for clock_step_control

module tb_clock_step_control;

  localparam int DC   = 4;
  localparam int CW   = 4;
  localparam int MAXN = 8192;

  localparam int MS_STOP = 0;
  localparam int MS_RUN  = 1;
  localparam int MS_HLT  = 2;

  logic          IN_CLK;
  logic          RST_N;
  logic          TICK_IN;
  logic          MODE_RUN;
  logic          STEP_BTN;
  logic          HALT;
  logic          CPU_EN;
  logic          RUNNING;
  logic          HALTED;
  logic [CW-1:0] STEP_CNT;

  int checks = 0;
  int errors = 0;

  clock_step_control #(
    .DEBOUNCE_CYCLES(DC),
    .CNT_W          (CW)
  ) dut (
    .IN_CLK  (IN_CLK),
    .RST_N   (RST_N),
    .TICK_IN (TICK_IN),
    .MODE_RUN(MODE_RUN),
    .STEP_BTN(STEP_BTN),
    .HALT    (HALT),
    .CPU_EN  (CPU_EN),
    .RUNNING (RUNNING),
    .HALTED  (HALTED),
    .STEP_CNT(STEP_CNT)
  );

  initial IN_CLK = 1'b0;
  always #5 IN_CLK = ~IN_CLK;

  // Reference model: input history indexed by clock edge since reset
  // release (edge 1 is the first edge with RST_N high).
  bit tick_h  [MAXN];
  bit mode_h  [MAXN];
  bit btn_h   [MAXN];
  bit press_h [MAXN];
  int n;
  int m_state;
  bit m_stable;
  bit m_en;
  int m_cnt;
  bit m_run;
  bit m_hlt;

  task automatic model_reset();
    for (int i = 0; i < MAXN; i++) begin
      tick_h[i] = 0; mode_h[i] = 0; btn_h[i] = 0; press_h[i] = 0;
    end
    n = 0; m_state = MS_STOP; m_stable = 0; m_en = 0; m_cnt = 0; m_run = 0; m_hlt = 0;
  endtask

  task automatic cyc();
    bit ms, tp, pp, h, en, all_diff, s;
    int nxt;
    @(posedge IN_CLK);
    if (n < MAXN - 1) n++;
    tick_h[n] = TICK_IN;
    mode_h[n] = MODE_RUN;
    btn_h[n]  = STEP_BTN;
    h  = HALT;
    ms = (n >= 3) ? mode_h[n-2] : 1'b0;
    tp = (n >= 6) && tick_h[n-4] && !tick_h[n-5];
    pp = (n >= 2) && press_h[n-1];
    case (m_state)
      MS_STOP: nxt = h ? MS_HLT : (ms ? MS_RUN : MS_STOP);
      MS_RUN:  nxt = h ? MS_HLT : (ms ? MS_RUN : MS_STOP);
      default: nxt = (!h && !ms) ? MS_STOP : MS_HLT;
    endcase
    en = !h && (nxt == m_state) &&
         ((m_state == MS_RUN && tp) || (m_state == MS_STOP && pp));
    all_diff = 1;
    for (int j = n - DC + 1; j <= n; j++) begin
      s = (j >= 3) ? btn_h[j-2] : 1'b0;
      if (s == m_stable) all_diff = 0;
    end
    press_h[n] = 0;
    if (all_diff) begin
      m_stable   = !m_stable;
      press_h[n] = m_stable;
    end
    m_en    = en;
    m_cnt   = (m_cnt + (en ? 1 : 0)) % (1 << CW);
    m_state = nxt;
    m_run   = (nxt == MS_RUN);
    m_hlt   = (nxt == MS_HLT);
    @(negedge IN_CLK);
  endtask

  task automatic reset_dut();
    RST_N = 1'b0;
    @(negedge IN_CLK);
    @(negedge IN_CLK);
    RST_N = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    RST_N = 1'b0; TICK_IN = 0; MODE_RUN = 0; STEP_BTN = 0; HALT = 0;
    #1;
    checks++; if (CPU_EN !== 1'b0)   begin errors++; $display("FAIL reset_cpu_en: got %b expected 0", CPU_EN); end
    checks++; if (RUNNING !== 1'b0)  begin errors++; $display("FAIL reset_running: got %b expected 0", RUNNING); end
    checks++; if (HALTED !== 1'b0)   begin errors++; $display("FAIL reset_halted: got %b expected 0", HALTED); end
    checks++; if (STEP_CNT !== 4'd0) begin errors++; $display("FAIL reset_step_cnt: got %0d expected 0", STEP_CNT); end
    @(negedge IN_CLK);
    RST_N = 1'b1;
    model_reset();
    for (int c = 0; c < 4; c++) begin
      cyc();
      checks++; if (CPU_EN !== 1'b0) begin errors++; $display("FAIL reset_idle_cpu_en: got %b expected 0", CPU_EN); end
    end
  endtask

  task automatic test_run_ticks();
    int pulses, last_rise;
    bit prev;
    reset_dut();
    MODE_RUN = 1; TICK_IN = 0; pulses = 0; last_rise = -100;
    for (int c = 0; c < 120; c++) begin
      prev    = TICK_IN;
      TICK_IN = ((c / 20) % 2) == 1;
      cyc();
      if (TICK_IN && !prev) last_rise = n;
      checks++; if (CPU_EN !== m_en) begin errors++; $display("FAIL run_cpu_en_model: got %b expected %b at edge %0d", CPU_EN, m_en, n); end
      if (CPU_EN === 1'b1) begin
        pulses++;
        checks++; if (n - last_rise != 4) begin errors++; $display("FAIL run_tick_latency: got %0d expected 4", n - last_rise); end
      end
    end
    checks++; if (RUNNING !== 1'b1)  begin errors++; $display("FAIL run_running: got %b expected 1", RUNNING); end
    checks++; if (pulses != 3)       begin errors++; $display("FAIL run_pulse_count: got %0d expected 3", pulses); end
    checks++; if (STEP_CNT !== 4'd3) begin errors++; $display("FAIL run_step_cnt: got %0d expected 3", STEP_CNT); end
  endtask

  task automatic test_step_bounce();
    bit pat [34];
    int pulses, early;
    for (int i = 0; i < 34; i++) pat[i] = (i < 4) ? ((i % 2) == 0) : (i < 14);
    reset_dut();
    MODE_RUN = 0; TICK_IN = 0; pulses = 0; early = 0;
    for (int c = 0; c < 6; c++) cyc();
    for (int c = 0; c < 34; c++) begin
      STEP_BTN = pat[c];
      cyc();
      checks++; if (CPU_EN !== m_en) begin errors++; $display("FAIL bounce_cpu_en_model: got %b expected %b at edge %0d", CPU_EN, m_en, n); end
      if (CPU_EN === 1'b1) begin
        pulses++;
        if (c < 7) early++;
      end
    end
    checks++; if (early != 0)        begin errors++; $display("FAIL bounce_early_pulse: got %0d expected 0", early); end
    checks++; if (pulses != 1)       begin errors++; $display("FAIL bounce_pulse_count: got %0d expected 1", pulses); end
    checks++; if (STEP_CNT !== 4'd1) begin errors++; $display("FAIL bounce_step_cnt: got %0d expected 1", STEP_CNT); end
  endtask

  task automatic test_halt();
    int pulses;
    reset_dut();
    MODE_RUN = 1; TICK_IN = 0; STEP_BTN = 0; HALT = 0; pulses = 0;
    for (int c = 0; c < 8; c++) cyc();
    checks++; if (RUNNING !== 1'b1) begin errors++; $display("FAIL halt_pre_running: got %b expected 1", RUNNING); end
    TICK_IN = 1;
    for (int c = 0; c < 4; c++) cyc();
    HALT = 1;
    cyc();
    checks++; if (CPU_EN !== 1'b0)  begin errors++; $display("FAIL halt_swallow_cpu_en: got %b expected 0", CPU_EN); end
    checks++; if (HALTED !== 1'b1)  begin errors++; $display("FAIL halt_halted: got %b expected 1", HALTED); end
    checks++; if (RUNNING !== 1'b0) begin errors++; $display("FAIL halt_running: got %b expected 0", RUNNING); end
    for (int c = 0; c < 60; c++) begin
      TICK_IN  = ((c / 5) % 2) == 0;
      STEP_BTN = (c < 40) && ((c / 10) % 2 == 1);
      cyc();
      if (CPU_EN === 1'b1) pulses++;
      checks++; if (CPU_EN !== m_en) begin errors++; $display("FAIL halt_cpu_en_model: got %b expected %b at edge %0d", CPU_EN, m_en, n); end
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL halt_no_pulses: got %0d expected 0", pulses); end
    MODE_RUN = 0;
    for (int c = 0; c < 4; c++) cyc();
    checks++; if (HALTED !== 1'b1) begin errors++; $display("FAIL halt_hold: got %b expected 1", HALTED); end
    HALT = 0;
    cyc();
    checks++; if (HALTED !== 1'b0)  begin errors++; $display("FAIL halt_release_halted: got %b expected 0", HALTED); end
    checks++; if (RUNNING !== 1'b0) begin errors++; $display("FAIL halt_release_running: got %b expected 0", RUNNING); end
  endtask

  task automatic test_step_wrap();
    reset_dut();
    MODE_RUN = 0; TICK_IN = 0; STEP_BTN = 0; HALT = 0;
    for (int c = 0; c < 4; c++) cyc();
    for (int p = 0; p < 18; p++) begin
      STEP_BTN = 1;
      for (int c = 0; c < 7; c++) cyc();
      STEP_BTN = 0;
      for (int c = 0; c < 7; c++) cyc();
      checks++;
      if (STEP_CNT !== 4'((p + 1) % 16)) begin
        errors++; $display("FAIL wrap_step_cnt: got %0d expected %0d after press %0d", STEP_CNT, (p + 1) % 16, p + 1);
      end
    end
    checks++; if (STEP_CNT !== 4'd2) begin errors++; $display("FAIL wrap_final: got %0d expected 2", STEP_CNT); end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    MODE_RUN = 1; TICK_IN = 0; STEP_BTN = 0; HALT = 0;
    for (int c = 0; c < 8; c++) cyc();
    TICK_IN = 1;
    for (int c = 0; c < 8; c++) cyc();
    TICK_IN = 0;
    for (int c = 0; c < 4; c++) cyc();
    checks++; if (STEP_CNT !== 4'd1) begin errors++; $display("FAIL mid_pre_step_cnt: got %0d expected 1", STEP_CNT); end
    TICK_IN = 1; STEP_BTN = 1;
    cyc();
    cyc();
    @(posedge IN_CLK);
    #2;
    RST_N = 1'b0;
    #1;
    checks++; if (CPU_EN !== 1'b0)   begin errors++; $display("FAIL mid_async_cpu_en: got %b expected 0", CPU_EN); end
    checks++; if (RUNNING !== 1'b0)  begin errors++; $display("FAIL mid_async_running: got %b expected 0", RUNNING); end
    checks++; if (HALTED !== 1'b0)   begin errors++; $display("FAIL mid_async_halted: got %b expected 0", HALTED); end
    checks++; if (STEP_CNT !== 4'd0) begin errors++; $display("FAIL mid_async_step_cnt: got %0d expected 0", STEP_CNT); end
    @(negedge IN_CLK);
    @(negedge IN_CLK);
    RST_N = 1'b1;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      cyc();
      checks++; if (CPU_EN !== 1'b0) begin errors++; $display("FAIL mid_post_release_cpu_en: got %b expected 0 in cycle %0d", CPU_EN, c + 1); end
    end
    for (int c = 0; c < 12; c++) begin
      cyc();
      checks++; if (CPU_EN !== m_en) begin errors++; $display("FAIL mid_cpu_en_model: got %b expected %b at edge %0d", CPU_EN, m_en, n); end
    end
    STEP_BTN = 0; TICK_IN = 0;
  endtask

  task automatic test_random();
    reset_dut();
    MODE_RUN = 0; TICK_IN = 0; STEP_BTN = 0; HALT = 0;
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 119) == 0) MODE_RUN = ~MODE_RUN;
      if ($urandom_range(0, 89) == 0)  HALT = ~HALT;
      if ($urandom_range(0, 7) == 0)   TICK_IN = ~TICK_IN;
      if ($urandom_range(0, 5) == 0)   STEP_BTN = ~STEP_BTN;
      cyc();
      checks++; if (CPU_EN !== m_en)          begin errors++; $display("FAIL rand_cpu_en: got %b expected %b at edge %0d", CPU_EN, m_en, n); end
      checks++; if (STEP_CNT !== 4'(m_cnt))   begin errors++; $display("FAIL rand_step_cnt: got %0d expected %0d at edge %0d", STEP_CNT, m_cnt, n); end
      checks++; if (RUNNING !== m_run)        begin errors++; $display("FAIL rand_running: got %b expected %b at edge %0d", RUNNING, m_run, n); end
      checks++; if (HALTED !== m_hlt)         begin errors++; $display("FAIL rand_halted: got %b expected %b at edge %0d", HALTED, m_hlt, n); end
    end
  endtask

  initial begin
    test_reset();
    test_run_ticks();
    test_step_bounce();
    test_halt();
    test_step_wrap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
